// File: rtl/delay_line_mc_pkg.sv
// Shared FFT helpers: width math, lane packing offsets and default stage-buffer sizing.
package delay_line_mc_pkg;

  // Default depth for stage buffers built by the FFT stage generators.
  localparam int DEFAULT_STAGE_DEPTH = 8;

  // Default lane geometry (re/im pairs of 16-bit samples).
  localparam int DEFAULT_LANE_WIDTH = 16;
  localparam int DEFAULT_CHANNELS   = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Bit offset of lane k in a packed multi-lane word.
  function automatic int lane_offset(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} element of the delay chain: advances on en, valid clears synchronously.
module delay_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Clear drops only the valid bit; data is left as-is since consumers ignore it when invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/delay_line_mc.sv
// Multi-lane delay line with run-time depth, valid tracking, in-flight count and primed flag.
module delay_line_mc
  import delay_line_mc_pkg::*;
#(
  parameter  int WIDTH     = DEFAULT_LANE_WIDTH,
  parameter  int CHANNELS  = DEFAULT_CHANNELS,
  parameter  int MAX_DEPTH = DEFAULT_STAGE_DEPTH,
  localparam int DW        = clog2(MAX_DEPTH + 1),
  localparam int DATA_W    = WIDTH * CHANNELS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flush,
  input  logic              load_cfg,
  input  logic [DW-1:0]     depth_in,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              d_valid,
  output logic [DW-1:0]     depth,
  output logic [DW-1:0]     in_flight,
  output logic              primed
);

  localparam logic [DW-1:0] MAX_DEPTH_W = DW'(MAX_DEPTH);

  // load_cfg carries an implicit flush.
  logic clear;
  assign clear = flush | load_cfg;

  logic [MAX_DEPTH-1:0] stage_valid;
  logic [DATA_W-1:0]    stage_data [MAX_DEPTH];

  // The full chain always shifts; depth only selects which stage feeds the output.
  for (genvar gi = 0; gi < MAX_DEPTH; gi++) begin : g_stage
    logic              valid_src;
    logic [DATA_W-1:0] data_src;
    if (gi == 0) begin : g_head
      assign valid_src = in_valid;
      assign data_src  = d_in;
    end else begin : g_link
      assign valid_src = stage_valid[gi-1];
      assign data_src  = stage_data[gi-1];
    end
    delay_stage #(.W(DATA_W)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en),
      .clr_i   (clear),
      .valid_i (valid_src),
      .data_i  (data_src),
      .valid_o (stage_valid[gi]),
      .data_o  (stage_data[gi])
    );
  end

  logic              tap_valid;
  logic [DATA_W-1:0] tap_data;
  logic [DW-1:0]     depth_q, depth_d, depth_clamped;
  logic [DW-1:0]     in_flight_q, in_flight_d;
  logic [DW-1:0]     fill_q, fill_d;
  logic              primed_q, primed_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  assign depth_clamped = (depth_in > MAX_DEPTH_W) ? MAX_DEPTH_W : depth_in;

  // Tap mux: stage[depth-1], or the live input when depth is 0 (plain 1-cycle register).
  always_comb begin
    tap_valid = in_valid;
    tap_data  = d_in;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) begin
        tap_valid = stage_valid[i];
        tap_data  = stage_data[i];
      end
    end
  end

  // Next-state for depth, counters, primed flag and output register.
  always_comb begin
    depth_d     = load_cfg ? depth_clamped : depth_q;
    in_flight_d = in_flight_q;
    fill_d      = fill_q;
    primed_d    = primed_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clear) begin
      in_flight_d = '0;
      fill_d      = '0;
      primed_d    = 1'b0;
      out_valid_d = 1'b0;
    end else if (en) begin
      if (depth_q != '0) begin
        if (in_valid && !tap_valid) begin
          in_flight_d = in_flight_q + 1'b1;
        end else if (!in_valid && tap_valid) begin
          in_flight_d = in_flight_q - 1'b1;
        end
      end
      if (fill_q < depth_q) begin
        fill_d = fill_q + 1'b1;
      end
      primed_d    = (fill_d == depth_q);
      out_valid_d = tap_valid;
      out_data_d  = tap_data;
    end
  end

  // State registers; reset restores the maximum depth and empties everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth_q     <= MAX_DEPTH_W;
      in_flight_q <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      depth_q     <= depth_d;
      in_flight_q <= in_flight_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign d_out     = out_data_q;
  assign d_valid   = out_valid_q;
  assign depth     = depth_q;
  assign in_flight = in_flight_q;
  assign primed    = primed_q;

endmodule

// File: tb/tb_delay_line_mc.sv
// Self-checking bench for delay_line_mc: directed corner cases, a depth table and a randomized run.
module tb_delay_line_mc;

  localparam int WIDTH     = 16;
  localparam int CHANNELS  = 2;
  localparam int MAX_DEPTH = 8;
  localparam int DW        = 4;
  localparam int DWID      = WIDTH * CHANNELS;
  localparam int HMAX      = 8192;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en = 1'b0;
  logic            flush = 1'b0;
  logic            load_cfg = 1'b0;
  logic [DW-1:0]   depth_in = '0;
  logic            in_valid = 1'b0;
  logic [DWID-1:0] d_in = '0;
  logic [DWID-1:0] d_out;
  logic            d_valid;
  logic [DW-1:0]   depth;
  logic [DW-1:0]   in_flight;
  logic            primed;

  int checks = 0;
  int failures = 0;

  delay_line_mc #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DEPTH(MAX_DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .flush     (flush),
    .load_cfg  (load_cfg),
    .depth_in  (depth_in),
    .in_valid  (in_valid),
    .d_in      (d_in),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .depth     (depth),
    .in_flight (in_flight),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  // Reference model: the list of samples taken on enabled edges since the last clear.
  // Output after edge n is sample n-depth; the stages hold the last depth samples.
  logic            hv [HMAX];
  logic [DWID-1:0] hd [HMAX];
  int n_m;
  int depth_m;

  task automatic model_reset();
    n_m = 0;
    depth_m = MAX_DEPTH;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (load_cfg) begin
      depth_m = (int'(depth_in) > MAX_DEPTH) ? MAX_DEPTH : int'(depth_in);
      n_m = 0;
    end else if (flush) begin
      n_m = 0;
    end else if (en && n_m < HMAX) begin
      hv[n_m] = in_valid;
      hd[n_m] = d_in;
      n_m++;
    end
  endtask

  function automatic logic exp_valid();
    int idx = n_m - depth_m - 1;
    return (idx >= 0) ? hv[idx] : 1'b0;
  endfunction

  function automatic logic [DWID-1:0] exp_data();
    int idx = n_m - depth_m - 1;
    return (idx >= 0) ? hd[idx] : '0;
  endfunction

  function automatic int exp_in_flight();
    int cnt = 0;
    int lo = (n_m > depth_m) ? n_m - depth_m : 0;
    for (int i = lo; i < n_m; i++) cnt += int'(hv[i]);
    return cnt;
  endfunction

  function automatic logic exp_primed();
    return (n_m > 0) && (n_m >= depth_m);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic ev;
    ev = exp_valid();
    check({tag, "_d_valid"}, 64'(d_valid), 64'(ev));
    if (ev) check({tag, "_d_out"}, 64'(d_out), 64'(exp_data()));
    check({tag, "_in_flight"}, 64'(in_flight), 64'(exp_in_flight()));
    check({tag, "_primed"}, 64'(primed), 64'(exp_primed()));
    check({tag, "_depth"}, 64'(depth), 64'(depth_m));
  endtask

  // Advance one clock; the model sees the same inputs as the DUT, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_depth(input int d);
    load_cfg = 1'b1;
    depth_in = DW'(d);
    tick();
    load_cfg = 1'b0;
  endtask

  // Send one valid beat and count enabled edges until it appears on d_out.
  task automatic measure_latency(input string name, input int exp_lat, input bit zero_inflight);
    logic [DWID-1:0] pat;
    int lat;
    bit seen;
    pat = DWID'($urandom);
    en = 1'b1;
    in_valid = 1'b1;
    d_in = pat;
    seen = 0;
    lat = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      in_valid = 1'b0;
      d_in = DWID'($urandom);
      if (zero_inflight) check({name, "_inflight_zero"}, 64'(in_flight), 64'd0);
      if (d_valid) begin
        seen = 1;
        lat = k;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    if (seen) check({name, "_data"}, 64'(d_out), 64'(pat));
  endtask

  typedef struct {
    logic [DW-1:0] din;
    int            exp_depth;
    int            exp_lat;
  } cfg_vec_t;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_vec_t tbl [6];
    logic [DWID-1:0] pattern;
    tbl[0] = '{din: 4'd12, exp_depth: 8, exp_lat: 9};
    tbl[1] = '{din: 4'd3,  exp_depth: 3, exp_lat: 4};
    tbl[2] = '{din: 4'd0,  exp_depth: 0, exp_lat: 1};
    tbl[3] = '{din: 4'd15, exp_depth: 8, exp_lat: 9};
    tbl[4] = '{din: 4'd5,  exp_depth: 5, exp_lat: 6};
    tbl[5] = '{din: 4'd1,  exp_depth: 1, exp_lat: 2};

    model_reset();

    // Reset held with random data, then released with en low: everything idle.
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_in = DWID'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_d_out", 64'(d_out), 64'd0);
      check("idle_d_valid", 64'(d_valid), 64'd0);
      check("idle_depth", 64'(depth), 64'd8);
      check("idle_in_flight", 64'(in_flight), 64'd0);
      check("idle_primed", 64'(primed), 64'd0);
    end
    $display("phase reset_idle done");

    // Single pulse at default depth 8.
    pattern = 32'hAAAA_5555;
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      in_valid = (k == 1);
      d_in = (k == 1) ? pattern : DWID'($urandom);
      tick();
      check($sformatf("pulse_d_valid_e%0d", k), 64'(d_valid), 64'(k == 9));
      if (k == 9) check("pulse_d_out", 64'(d_out), 64'(pattern));
      check($sformatf("pulse_primed_e%0d", k), 64'(primed), 64'(k >= 8));
      check($sformatf("pulse_in_flight_e%0d", k), 64'(in_flight), 64'(k <= 8));
    end
    in_valid = 1'b0;
    $display("phase default_latency done");

    // Depth table: load (with en low), verify cleared status, then measure latency.
    foreach (tbl[i]) begin
      en = 1'b0;
      load_depth(int'(tbl[i].din));
      check($sformatf("tbl%0d_depth", i), 64'(depth), 64'(tbl[i].exp_depth));
      check($sformatf("tbl%0d_in_flight", i), 64'(in_flight), 64'd0);
      check($sformatf("tbl%0d_primed", i), 64'(primed), 64'd0);
      measure_latency($sformatf("tbl%0d", i), tbl[i].exp_lat, tbl[i].exp_depth == 0);
      $display("vector %0d depth_in=%0d depth=%0d", i, tbl[i].din, depth);
    end

    // Continuous stream at depth 3: value n appears after edge n+4.
    en = 1'b1;
    load_depth(3);
    for (int e = 1; e <= 12; e++) begin
      in_valid = 1'b1;
      d_in = DWID'(e - 1);
      tick();
      check($sformatf("stream3_valid_e%0d", e), 64'(d_valid), 64'(e >= 4));
      if (e >= 4) check($sformatf("stream3_data_e%0d", e), 64'(d_out), 64'(e - 4));
    end
    in_valid = 1'b0;
    $display("phase stream_depth3 done");

    // Flush mid-stream at depth 4 with three beats in flight.
    load_depth(4);
    en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = DWID'($urandom);
      tick();
    end
    check("flush_pre_in_flight", 64'(in_flight), 64'd3);
    flush = 1'b1;
    d_in = DWID'($urandom);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_d_valid", 64'(d_valid), 64'd0);
    check("flush_in_flight", 64'(in_flight), 64'd0);
    check("flush_primed", 64'(primed), 64'd0);
    check("flush_depth", 64'(depth), 64'd4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("flush_no_stale_valid", 64'(d_valid), 64'd0);
      check("flush_post_in_flight", 64'(in_flight), 64'd0);
    end
    $display("phase flush done");

    // Randomized run with stalls, flushes and reloads against the model.
    load_depth(4);
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 2) != 0);
      in_valid = $urandom_range(0, 1);
      d_in = DWID'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      load_cfg = ($urandom_range(0, 59) == 0);
      depth_in = DW'($urandom_range(0, 15));
      tick();
      check_model($sformatf("rand%0d", c));
    end
    flush = 1'b0;
    load_cfg = 1'b0;
    $display("phase random done");

    // Async reset mid-cycle while the chain is full at depth 3.
    load_depth(3);
    en = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d_in = DWID'($urandom);
      tick();
    end
    in_valid = 1'b0;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("areset_d_valid", 64'(d_valid), 64'd0);
    check("areset_d_out", 64'(d_out), 64'd0);
    check("areset_in_flight", 64'(in_flight), 64'd0);
    check("areset_primed", 64'(primed), 64'd0);
    check("areset_depth", 64'(depth), 64'd8);
    tick();
    reset_n = 1'b1;
    measure_latency("areset_relaunch", 9, 1'b0);
    $display("phase async_reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
